// File: rtl/sd_sector_buffer_ctrl.sv
// sd_sector_buffer_ctrl
//   Host-facing front end for the SD card controller. Owns the 512-byte
//   sector buffer, drives the controller's control register and sector
//   address, serves its byte-wise buffer accesses, and captures the status
//   byte when the controller finishes.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_valid/i_cmd_write      host command (1 = write sector, 0 = read)
//   i_sector                     host sector number
//   o_cmd_ready                  high only in IDLE
//   o_done                       one-cycle completion pulse
//   o_timeout                    sticky timeout flag, cleared on next accept
//   o_status                     captured controller status (8'hFF on timeout)
//   i_buf_addr/i_buf_we/
//   i_buf_wdata/o_buf_rdata      host random access to the buffer (1-cycle read)
//   o_controlreg/o_addr          op code and sector address to the controller
//   i_statusreg/i_write_statusreg status byte and its strobe from the controller
//   i_mem_addr/i_mem_wr_nrd/
//   i_mem_req/i_mem_wdata/
//   o_mem_rdata                  controller byte-wise buffer port
//
// Optional build macro SD_SECT_BYTE_COUNT_EN adds a saturating count of the
// controller buffer accesses (o_byte_count) and flags a short transfer by
// forcing o_status[7] in DONE.

module sd_sector_buffer_ctrl #(
    parameter int BYTE_ADDR      = 0,
    parameter int TRIGGER_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    input  logic        i_cmd_write,
    input  logic [31:0] i_sector,
    output logic        o_cmd_ready,
    output logic        o_done,
    output logic        o_timeout,
    output logic [7:0]  o_status,
    input  logic [8:0]  i_buf_addr,
    input  logic        i_buf_we,
    input  logic [7:0]  i_buf_wdata,
    output logic [7:0]  o_buf_rdata,
    output logic [7:0]  o_controlreg,
    output logic [31:0] o_addr,
    input  logic [7:0]  i_statusreg,
    input  logic        i_write_statusreg,
    input  logic [31:0] i_mem_addr,
    input  logic        i_mem_wr_nrd,
    input  logic        i_mem_req,
    input  logic [7:0]  i_mem_wdata,
    output logic [7:0]  o_mem_rdata
`ifdef SD_SECT_BYTE_COUNT_EN
    ,
    output logic [9:0]  o_byte_count
`endif
);

    localparam int TRIG_W = $clog2(TRIGGER_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_TRIGGER, S_WAIT, S_DONE} state_t;

    state_t             state, state_d;
    logic               accept, strobe_hit, tmo_hit, active;
    logic               op_write;
    logic [TRIG_W-1:0]  trig_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [7:0]         mem [0:511];
    logic               host_we, ctrl_we, mem_we;
    logic [8:0]         mem_waddr;
    logic [7:0]         mem_wdata;

    // Only the low 9 address bits select a byte; the rest wrap away.
    logic               unused_mem_addr_hi;
    assign unused_mem_addr_hi = ^i_mem_addr[31:9];

`ifdef SD_SECT_BYTE_COUNT_EN
    logic [9:0]         byte_cnt;
    logic               ctrl_acc;

    function automatic logic [9:0] sat_inc_512(input logic [9:0] v);
        return (v >= 10'd512) ? 10'd512 : v + 10'd1;
    endfunction

    // Data-moving accesses only: writes on a read command, reads on a write.
    assign ctrl_acc     = i_mem_req & active & (op_write ? ~i_mem_wr_nrd : i_mem_wr_nrd);
    assign o_byte_count = byte_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt <= 10'd0;
        end else if (accept) begin
            byte_cnt <= 10'd0;
        end else if (ctrl_acc) begin
            byte_cnt <= sat_inc_512(byte_cnt);
        end
    end
`endif

    assign active      = (state == S_TRIGGER) || (state == S_WAIT);
    assign o_cmd_ready = (state == S_IDLE);
    assign o_done      = (state == S_DONE);

    // Next-state logic. A status strobe beats a coincident timeout, and a
    // strobe during TRIGGER short-circuits straight to DONE.
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        strobe_hit = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    accept  = 1'b1;
                    state_d = S_TRIGGER;
                end
            end
            S_TRIGGER, S_WAIT: begin
                if (i_write_statusreg) begin
                    strobe_hit = 1'b1;
                    state_d    = S_DONE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = S_DONE;
                end else if ((state == S_TRIGGER) &&
                             (trig_cnt == TRIG_W'(TRIGGER_CYCLES - 1))) begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            op_write     <= 1'b0;
            o_controlreg <= 8'd0;
            o_addr       <= 32'd0;
            o_status     <= 8'd0;
            o_timeout    <= 1'b0;
            trig_cnt     <= '0;
            tmo_cnt      <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_write     <= i_cmd_write;
                o_addr       <= (BYTE_ADDR != 0) ? {i_sector[22:0], 9'b0} : i_sector;
                o_controlreg <= i_cmd_write ? 8'd2 : 8'd1;
                o_timeout    <= 1'b0;
                trig_cnt     <= '0;
                tmo_cnt      <= '0;
            end else begin
                // Drop the op code whenever TRIGGER is left, by any exit.
                if ((state == S_TRIGGER) && (state_d != S_TRIGGER)) begin
                    o_controlreg <= 8'd0;
                end
                if (state == S_TRIGGER) begin
                    trig_cnt <= trig_cnt + TRIG_W'(1);
                end
                if (active) begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                if (strobe_hit) begin
                    o_status <= i_statusreg;
                end
                if (tmo_hit) begin
                    o_status  <= 8'hFF;
                    o_timeout <= 1'b1;
                end
`ifdef SD_SECT_BYTE_COUNT_EN
                if ((state == S_DONE) && (byte_cnt != 10'd512) && !o_timeout) begin
                    o_status[7] <= 1'b1;
                end
`endif
            end
        end
    end

    // Host writes (IDLE only) and controller writes (read command in
    // progress only) can never coincide, so one write port suffices.
    assign host_we   = i_buf_we & o_cmd_ready;
    assign ctrl_we   = i_mem_req & i_mem_wr_nrd & active & ~op_write;
    assign mem_we    = host_we | ctrl_we;
    assign mem_waddr = host_we ? i_buf_addr  : i_mem_addr[8:0];
    assign mem_wdata = host_we ? i_buf_wdata : i_mem_wdata;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered reads see pre-write contents on a same-cycle collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_buf_rdata <= 8'd0;
            o_mem_rdata <= 8'd0;
        end else begin
            o_buf_rdata <= mem[i_buf_addr];
            o_mem_rdata <= mem[i_mem_addr[8:0]];
        end
    end

endmodule

// File: tb/tb_sd_sector_buffer_ctrl.sv
// Testbench for sd_sector_buffer_ctrl. Two instances share the host and
// controller stimulus: u0 is block-addressed with a long timeout, u1 is
// byte-addressed with TIMEOUT_CYCLES=200.

module tb_sd_sector_buffer_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, cmd_valid0, cmd_valid1, cmd_write;
    logic [31:0] sector;
    logic [8:0]  buf_addr;
    logic        buf_we;
    logic [7:0]  buf_wdata;
    logic [7:0]  statusreg;
    logic        write_statusreg;
    logic [31:0] mem_addr;
    logic        mem_wr_nrd, mem_req;
    logic [7:0]  mem_wdata;

    logic        ready0, done0, timeout0, ready1, done1, timeout1;
    logic [7:0]  status0, buf_rdata0, ctl0, mem_rdata0;
    logic [7:0]  status1, buf_rdata1, ctl1, mem_rdata1;
    logic [31:0] addr0, addr1;
`ifdef SD_SECT_BYTE_COUNT_EN
    logic [9:0]  bc0, bc1;
`endif

    sd_sector_buffer_ctrl #(.BYTE_ADDR(0), .TRIGGER_CYCLES(64), .TIMEOUT_CYCLES(1000)) u0 (
        .i_clk(clk), .i_rst(rst0), .i_cmd_valid(cmd_valid0), .i_cmd_write(cmd_write),
        .i_sector(sector), .o_cmd_ready(ready0), .o_done(done0), .o_timeout(timeout0),
        .o_status(status0), .i_buf_addr(buf_addr), .i_buf_we(buf_we), .i_buf_wdata(buf_wdata),
        .o_buf_rdata(buf_rdata0), .o_controlreg(ctl0), .o_addr(addr0), .i_statusreg(statusreg),
        .i_write_statusreg(write_statusreg), .i_mem_addr(mem_addr), .i_mem_wr_nrd(mem_wr_nrd),
        .i_mem_req(mem_req), .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata0)
`ifdef SD_SECT_BYTE_COUNT_EN
        , .o_byte_count(bc0)
`endif
    );

    sd_sector_buffer_ctrl #(.BYTE_ADDR(1), .TRIGGER_CYCLES(64), .TIMEOUT_CYCLES(200)) u1 (
        .i_clk(clk), .i_rst(rst1), .i_cmd_valid(cmd_valid1), .i_cmd_write(cmd_write),
        .i_sector(sector), .o_cmd_ready(ready1), .o_done(done1), .o_timeout(timeout1),
        .o_status(status1), .i_buf_addr(buf_addr), .i_buf_we(buf_we), .i_buf_wdata(buf_wdata),
        .o_buf_rdata(buf_rdata1), .o_controlreg(ctl1), .o_addr(addr1), .i_statusreg(statusreg),
        .i_write_statusreg(write_statusreg), .i_mem_addr(mem_addr), .i_mem_wr_nrd(mem_wr_nrd),
        .i_mem_req(mem_req), .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata1)
`ifdef SD_SECT_BYTE_COUNT_EN
        , .o_byte_count(bc1)
`endif
    );

    int checks = 0;
    int errors = 0;
    int ones, dones, got;

    typedef struct {
        logic        we;
        logic [8:0]  baddr;
        logic [7:0]  wdata;
        logic [31:0] maddr;
        logic        chk_b;
        logic [7:0]  exp_b;
        logic        chk_m;
        logic [7:0]  exp_m;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; cmd_valid0 = 1'b0; cmd_valid1 = 1'b0; cmd_write = 1'b0;
        sector = 32'd0; buf_addr = 9'd0; buf_we = 1'b0; buf_wdata = 8'd0;
        statusreg = 8'd0; write_statusreg = 1'b0; mem_addr = 32'd0;
        mem_wr_nrd = 1'b0; mem_req = 1'b0; mem_wdata = 8'd0;

        // Host-port / controller-port buffer vectors, all applied in IDLE.
        vt[0] = '{1'b1, 9'h010, 8'hA5, 32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00};
        vt[1] = '{1'b1, 9'h1FF, 8'h3C, 32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[2] = '{1'b0, 9'h1FF, 8'h00, 32'h0000_0210, 1'b1, 8'h3C, 1'b1, 8'hA5};
        vt[3] = '{1'b1, 9'h010, 8'h5A, 32'h0000_0010, 1'b1, 8'hA5, 1'b1, 8'hA5};
        vt[4] = '{1'b0, 9'h010, 8'h00, 32'hFFFF_FFFF, 1'b1, 8'h5A, 1'b1, 8'h3C};
        vt[5] = '{1'b0, 9'h1FF, 8'h00, 32'h0000_03FF, 1'b1, 8'h3C, 1'b1, 8'h3C};

        // Reset values
        repeat (2) tick;
        chk("rst_ready", ready0, 1);
        chk("rst_ctl", ctl0, 0);
        chk("rst_status", status0, 0);
        chk("rst_done", done0, 0);
        chk("rst_timeout", timeout0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_buf_rdata", buf_rdata0, 0);
        chk("rst_mem_rdata", mem_rdata0, 0);
        chk("rst_ready1", ready1, 1);
        rst0 = 1'b0; rst1 = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done0 || done1) dones++;
        end
        chk("idle_no_done", dones, 0);

        // Table-driven buffer access
        for (int v = 0; v < 6; v++) begin
            buf_we = vt[v].we; buf_addr = vt[v].baddr; buf_wdata = vt[v].wdata;
            mem_addr = vt[v].maddr;
            tick;
            if (vt[v].chk_b) chk($sformatf("vec%0d_buf_rdata", v), buf_rdata0, vt[v].exp_b);
            if (vt[v].chk_m) chk($sformatf("vec%0d_mem_rdata", v), mem_rdata0, vt[v].exp_m);
        end
        buf_we = 1'b0;

        // Read sector 5 on the block-addressed instance
        sector = 32'd5; cmd_write = 1'b0; cmd_valid0 = 1'b1;
        tick;
        cmd_valid0 = 1'b0;
        chk("rd_ctl_first", ctl0, 1);
        chk("rd_addr", addr0, 32'd5);
        chk("rd_ready_low", ready0, 0);
        ones  = (ctl0 == 8'd1) ? 1 : 0;
        dones = 0;
        for (int k = 0; k < 512; k++) begin
            mem_req = 1'b1; mem_wr_nrd = 1'b1; mem_addr = k; mem_wdata = 8'(k);
            tick;
            if (ctl0 == 8'd1) ones++;
            if (done0) dones++;
        end
        mem_req = 1'b0; mem_wr_nrd = 1'b0;
        chk("rd_ctl_cycles", ones, 64);
        chk("rd_ctl_after", ctl0, 0);
        buf_we = 1'b1; buf_addr = 9'd0; buf_wdata = 8'hEE;
        tick;
        buf_we = 1'b0;
        statusreg = 8'h00; write_statusreg = 1'b1;
        tick;
        if (done0) dones++;
        chk("rd_done_pulse", done0, 1);
        statusreg = 8'h33;
        tick;
        if (done0) dones++;
        write_statusreg = 1'b0;
        chk("rd_done_once", dones, 1);
        chk("rd_status", status0, 8'h00);
        chk("rd_no_timeout", timeout0, 0);
        chk("rd_ready_back", ready0, 1);
        buf_addr = 9'd300;
        tick;
        chk("rd_host_300", buf_rdata0, 8'h2C);
        buf_addr = 9'd0;
        tick;
        chk("wait_host_we_ignored", buf_rdata0, 8'h00);
        mem_req = 1'b1; mem_wr_nrd = 1'b1; mem_addr = 32'd300; mem_wdata = 8'h99;
        tick;
        mem_req = 1'b0; mem_wr_nrd = 1'b0;
        buf_addr = 9'd300;
        tick;
        chk("idle_ctrl_we_ignored", buf_rdata0, 8'h2C);

        // Write sector 0x0012_3456 on the byte-addressed instance
        for (int i = 0; i < 512; i++) begin
            buf_we = 1'b1; buf_addr = 9'(i); buf_wdata = ~8'(i);
            tick;
        end
        buf_we = 1'b0;
        sector = 32'h0012_3456; cmd_write = 1'b1; cmd_valid1 = 1'b1;
        tick;
        cmd_valid1 = 1'b0;
        chk("wr_ctl", ctl1, 2);
        chk("wr_addr", addr1, 32'h2468_AC00);
        mem_req = 1'b1; mem_wr_nrd = 1'b0; mem_addr = 32'd3;
        tick;
        mem_req = 1'b0;
        chk("wr_mem_rdata", mem_rdata1, 8'hFC);
        statusreg = 8'h05; write_statusreg = 1'b1;
        tick;
        write_statusreg = 1'b0;
        chk("wr_done_in_trigger", done1, 1);
        chk("wr_ctl_cleared", ctl1, 0);
        chk("wr_status", status1, 8'h05);
        tick;
        chk("wr_done_single", done1, 0);
        chk("wr_ready_back", ready1, 1);

        // Timeout with TIMEOUT_CYCLES=200
        sector = 32'd1; cmd_write = 1'b0; cmd_valid1 = 1'b1;
        tick;
        cmd_valid1 = 1'b0;
        got = 0;
        for (int c = 1; c <= 300; c++) begin
            tick;
            if (done1) begin
                got = c;
                break;
            end
        end
        chk("tmo_done_cycle", got, 200);
        chk("tmo_flag", timeout1, 1);
        chk("tmo_status", status1, 8'hFF);
        chk("tmo_ctl", ctl1, 0);
        tick;
        chk("tmo_sticky", timeout1, 1);
        cmd_write = 1'b1; cmd_valid1 = 1'b1;
        tick;
        cmd_valid1 = 1'b0;
        chk("tmo_cleared_on_accept", timeout1, 0);
        chk("tmo_next_ctl", ctl1, 2);
        statusreg = 8'h00; write_statusreg = 1'b1;
        tick;
        write_statusreg = 1'b0;
        chk("tmo_next_done", done1, 1);
        tick;

        // Reset mid-command: during TRIGGER, then during WAIT
        cmd_write = 1'b0; sector = 32'd7; cmd_valid0 = 1'b1;
        tick;
        cmd_valid0 = 1'b0;
        repeat (3) tick;
        chk("rstt_ctl_before", ctl0, 1);
        rst0 = 1'b1;
        tick;
        rst0 = 1'b0;
        chk("rstt_ctl_after", ctl0, 0);
        chk("rstt_ready", ready0, 1);
        cmd_valid0 = 1'b1;
        tick;
        cmd_valid0 = 1'b0;
        repeat (70) tick;
        chk("rstw_in_wait", ready0, 0);
        rst0 = 1'b1;
        tick;
        rst0 = 1'b0;
        chk("rstw_ready", ready0, 1);
        chk("rstw_ctl", ctl0, 0);
        statusreg = 8'h44; write_statusreg = 1'b1;
        tick;
        write_statusreg = 1'b0;
        chk("rstw_strobe_no_done", done0, 0);
        tick;
        chk("rstw_strobe_no_done2", done0, 0);
        chk("rstw_status_kept", status0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
